// File: rtl/usb_uart_bridge.sv
// usb_uart_bridge
// Connects the picosoc memory-mapped UART register pair to the USB CDC
// valid/ready byte stream. TX bytes from the CPU and RX bytes from USB are
// held in small circular FIFOs. CPU writes to a full TX FIFO stall through
// reg_dat_wait. The stall is bounded by WAIT_TIMEOUT cycles, after which the
// byte is dropped and a sticky drop flag is set.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//                          (deassertion must already be synchronous to clk)
//   reg_dat_we/re/di/do    data register: write pushes TX, read pops RX
//   reg_dat_wait           write stall while TX is full
//   reg_stat_we/di/do      status/control: levels, drop flag (W1C), flushes
//   uart_in_data/valid     TX byte towards USB, popped on uart_in_ready
//   uart_out_data/valid    RX byte from USB, accepted while uart_out_ready
module usb_uart_bridge #(
    parameter int TX_DEPTH     = 8,
    parameter int RX_DEPTH     = 8,
    parameter int WAIT_TIMEOUT = 4800
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait,
    input  logic [3:0]  reg_stat_we,
    input  logic [31:0] reg_stat_di,
    output logic [31:0] reg_stat_do,
    output logic [7:0]  uart_in_data,
    output logic        uart_in_valid,
    input  logic        uart_in_ready,
    input  logic [7:0]  uart_out_data,
    input  logic        uart_out_valid,
    output logic        uart_out_ready
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_CW = RX_AW + 1;
    localparam int TO_W  = $clog2(WAIT_TIMEOUT) + 1;

    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(WAIT_TIMEOUT - 1);

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [RX_AW-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [TX_CW-1:0] tx_count_r;
    logic [RX_CW-1:0] rx_count_r;
    logic [TO_W-1:0]  wait_cnt_r;
    logic             drop_r;

    logic tx_full_s, rx_nonempty_s, stalled_s, expire_s;
    logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic flush_tx_s, flush_rx_s, drop_clr_s;
    logic unused_bits_s;

    // Handshake decode, FIFO operations and combinational register outputs.
    always_comb begin
        tx_full_s     = (tx_count_r == TX_FULL_CNT);
        rx_nonempty_s = (rx_count_r != {RX_CW{1'b0}});
        stalled_s     = reg_dat_we && tx_full_s;
        expire_s      = stalled_s && (wait_cnt_r == TO_LAST);
        flush_rx_s    = reg_stat_we[3] && reg_stat_di[31];
        flush_tx_s    = reg_stat_we[3] && reg_stat_di[30];
        drop_clr_s    = reg_stat_we[2] && reg_stat_di[18];

        uart_in_valid  = (tx_count_r != {TX_CW{1'b0}});
        uart_in_data   = tx_mem[tx_rd_ptr_r];
        uart_out_ready = (rx_count_r != RX_FULL_CNT);
        reg_dat_wait   = stalled_s && !expire_s;

        // A flush discards any same-edge push or pop on that FIFO.
        tx_push_s = reg_dat_we && !tx_full_s && !flush_tx_s;
        tx_pop_s  = uart_in_valid && uart_in_ready && !flush_tx_s;
        rx_push_s = uart_out_valid && uart_out_ready && !flush_rx_s;
        rx_pop_s  = reg_dat_re && rx_nonempty_s && !flush_rx_s;

        if (rx_nonempty_s) begin
            reg_dat_do = {24'h00_0000, rx_mem[rx_rd_ptr_r]};
        end else begin
            reg_dat_do = 32'hFFFF_FFFF;
        end

        reg_stat_do = {13'h0000, drop_r, tx_full_s, rx_nonempty_s,
                       8'(tx_count_r), 8'(rx_count_r)};

        unused_bits_s = ^{reg_dat_di[31:8], reg_stat_we[1:0], reg_stat_di[29:19],
                          reg_stat_di[17:0]};
    end

    // FIFO storage; contents need no reset because counts gate every read.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem[tx_wr_ptr_r] <= reg_dat_di[7:0];
        end
        if (rx_push_s) begin
            rx_mem[rx_wr_ptr_r] <= uart_out_data;
        end
    end

    // TX FIFO pointers and count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wr_ptr_r <= {TX_AW{1'b0}};
            tx_rd_ptr_r <= {TX_AW{1'b0}};
            tx_count_r  <= {TX_CW{1'b0}};
        end else if (flush_tx_s) begin
            tx_wr_ptr_r <= {TX_AW{1'b0}};
            tx_rd_ptr_r <= {TX_AW{1'b0}};
            tx_count_r  <= {TX_CW{1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + TX_AW'(1);
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + TX_AW'(1);
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + TX_CW'(1);
                2'b01:   tx_count_r <= tx_count_r - TX_CW'(1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // RX FIFO pointers and count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_wr_ptr_r <= {RX_AW{1'b0}};
            rx_rd_ptr_r <= {RX_AW{1'b0}};
            rx_count_r  <= {RX_CW{1'b0}};
        end else if (flush_rx_s) begin
            rx_wr_ptr_r <= {RX_AW{1'b0}};
            rx_rd_ptr_r <= {RX_AW{1'b0}};
            rx_count_r  <= {RX_CW{1'b0}};
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + RX_AW'(1);
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + RX_AW'(1);
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + RX_CW'(1);
                2'b01:   rx_count_r <= rx_count_r - RX_CW'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // Write-stall timeout counter and sticky drop flag (a set beats a clear).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_r <= {TO_W{1'b0}};
            drop_r     <= 1'b0;
        end else begin
            if (stalled_s && !expire_s) begin
                wait_cnt_r <= wait_cnt_r + TO_W'(1);
            end else begin
                wait_cnt_r <= {TO_W{1'b0}};
            end
            if (expire_s) begin
                drop_r <= 1'b1;
            end else if (drop_clr_s) begin
                drop_r <= 1'b0;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

endmodule

// File: tb/tb_usb_uart_bridge.sv
// Self-checking bench for usb_uart_bridge: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_usb_uart_bridge;

    localparam int DEPTH = 8;
    localparam int WT    = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        reg_dat_we, reg_dat_re;
    logic [31:0] reg_dat_di, reg_dat_do;
    logic        reg_dat_wait;
    logic [3:0]  reg_stat_we;
    logic [31:0] reg_stat_di, reg_stat_do;
    logic [7:0]  uart_in_data;
    logic        uart_in_valid, uart_in_ready;
    logic [7:0]  uart_out_data;
    logic        uart_out_valid, uart_out_ready;

    usb_uart_bridge #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .WAIT_TIMEOUT(WT)) dut (
        .clk(clk), .resetn(resetn),
        .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re),
        .reg_dat_di(reg_dat_di), .reg_dat_do(reg_dat_do),
        .reg_dat_wait(reg_dat_wait),
        .reg_stat_we(reg_stat_we), .reg_stat_di(reg_stat_di),
        .reg_stat_do(reg_stat_do),
        .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid),
        .uart_in_ready(uart_in_ready),
        .uart_out_data(uart_out_data), .uart_out_valid(uart_out_valid),
        .uart_out_ready(uart_out_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    byte unsigned tx_q[$];
    byte unsigned rx_q[$];
    bit           drop_m;
    int           wcnt_m;
    bit           last_wait, last_out_ready;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reg_dat_we = 1'b0; reg_dat_re = 1'b0; reg_dat_di = 32'h0;
        reg_stat_we = 4'h0; reg_stat_di = 32'h0;
        uart_in_ready = 1'b0; uart_out_valid = 1'b0; uart_out_data = 8'h00;
    endtask

    task automatic model_clear();
        tx_q.delete(); rx_q.delete(); drop_m = 1'b0; wcnt_m = 0;
    endtask

    // One clock: compare outputs before the edge, then advance the model.
    task automatic cycle();
        bit full, expire, txpop, txpush, rxpop, rxpush;
        logic [31:0] stat_e;
        #4;
        full   = (tx_q.size() == DEPTH);
        expire = reg_dat_we && full && (wcnt_m == WT - 1);
        check("wait", reg_dat_wait, reg_dat_we && full && !expire);
        check("in_valid", uart_in_valid, tx_q.size() != 0);
        if (tx_q.size() != 0) check("in_data", uart_in_data, tx_q[0]);
        check("out_ready", uart_out_ready, rx_q.size() != DEPTH);
        check("dat_do", reg_dat_do, (rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF);
        stat_e = {13'h0, drop_m, full, rx_q.size() != 0, 8'(tx_q.size()), 8'(rx_q.size())};
        check("stat", reg_stat_do, stat_e);
        last_wait      = reg_dat_wait;
        last_out_ready = uart_out_ready;
        @(posedge clk);
        txpop  = (tx_q.size() != 0) && uart_in_ready;
        txpush = reg_dat_we && !full;
        rxpop  = reg_dat_re && (rx_q.size() != 0);
        rxpush = uart_out_valid && (rx_q.size() != DEPTH);
        if (reg_stat_we[3] && reg_stat_di[30]) tx_q.delete();
        else begin
            if (txpop) void'(tx_q.pop_front());
            if (txpush) tx_q.push_back(reg_dat_di[7:0]);
        end
        if (reg_stat_we[3] && reg_stat_di[31]) rx_q.delete();
        else begin
            if (rxpop) void'(rx_q.pop_front());
            if (rxpush) rx_q.push_back(uart_out_data);
        end
        if (expire) drop_m = 1'b1;
        else if (reg_stat_we[2] && reg_stat_di[18]) drop_m = 1'b0;
        wcnt_m = (reg_dat_we && full && !expire) ? wcnt_m + 1 : 0;
        #1;
    endtask

    task automatic write_bytes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            reg_dat_we = 1'b1; reg_dat_di = 32'(base + i);
            cycle();
        end
        reg_dat_we = 1'b0;
    endtask

    initial begin
        int hi_cnt, idx, n;
        idle();
        model_clear();
        resetn = 1'b0;
        #12;
        check("rst_wait", reg_dat_wait, 1'b0);
        check("rst_valid", uart_in_valid, 1'b0);
        check("rst_ready", uart_out_ready, 1'b1);
        check("rst_dat_do", reg_dat_do, 32'hFFFF_FFFF);
        check("rst_stat", reg_stat_do, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        cycle();

        // 1: three writes streamed out with ready high
        uart_in_ready = 1'b1;
        write_bytes(3, 8'h41);
        for (int i = 0; i < 3; i++) cycle();
        check("t1_txcnt", reg_stat_do[15:8], 8'd0);

        // 2: fill TX, hold a 9th write, release ready after 10 cycles
        uart_in_ready = 1'b0;
        write_bytes(8, 8'h10);
        reg_dat_we = 1'b1; reg_dat_di = 32'h99;
        for (int i = 0; i < 10; i++) cycle();
        check("t2_stalled", last_wait, 1'b1);
        uart_in_ready = 1'b1;
        for (int i = 0; i < 5 && last_wait; i++) cycle();
        check("t2_accepted", last_wait, 1'b0);
        reg_dat_we = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("t2_drop", reg_stat_do[18], 1'b0);
        check("t2_txcnt", reg_stat_do[15:8], 8'd0);

        // 3: timeout on a full TX FIFO, then clear the drop flag
        uart_in_ready = 1'b0;
        write_bytes(8, 8'h20);
        reg_dat_we = 1'b1; reg_dat_di = 32'h55;
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (!last_wait) break;
            hi_cnt++;
        end
        check("t3_wait_cycles", hi_cnt, WT - 1);
        reg_dat_we = 1'b0;
        cycle();
        check("t3_drop_set", reg_stat_do[18], 1'b1);
        reg_stat_we = 4'b0100; reg_stat_di = 32'h0004_0000;
        cycle();
        idle();
        check("t3_drop_clr", reg_stat_do[18], 1'b0);
        uart_in_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        // 4: USB pushes 0..9 with no reads, then CPU drains
        idle();
        uart_out_valid = 1'b1; idx = 0;
        for (int i = 0; i < 12; i++) begin
            uart_out_data = 8'(idx);
            cycle();
            if (last_out_ready) idx++;
        end
        check("t4_accepted", idx, 8);
        check("t4_ready_low", uart_out_ready, 1'b0);
        reg_dat_re = 1'b1;
        n = 0;
        while (n < 40 && (idx < 10 || rx_q.size() != 0)) begin
            uart_out_valid = (idx < 10);
            uart_out_data = 8'(idx);
            cycle();
            if (uart_out_valid && last_out_ready) idx++;
            n++;
        end
        uart_out_valid = 1'b0;
        cycle();
        check("t4_empty_read", reg_dat_do, 32'hFFFF_FFFF);
        check("t4_rxcnt", reg_stat_do[7:0], 8'd0);

        // 5: push+pop at count 3, then TX flush against a push
        idle();
        write_bytes(3, 8'h60);
        reg_dat_we = 1'b1; reg_dat_di = 32'h63; uart_in_ready = 1'b1;
        cycle();
        idle();
        check("t5_txcnt3", reg_stat_do[15:8], 8'd3);
        reg_dat_we = 1'b1; reg_dat_di = 32'h70;
        reg_stat_we = 4'b1000; reg_stat_di = 32'h4000_0000;
        cycle();
        idle();
        check("t5_flush_cnt", reg_stat_do[15:8], 8'd0);
        check("t5_flush_valid", uart_in_valid, 1'b0);

        // 6: reset during a stalled write with both FIFOs non-empty
        write_bytes(8, 8'h80);
        uart_out_valid = 1'b1; uart_out_data = 8'hC3;
        for (int i = 0; i < 3; i++) cycle();
        uart_out_valid = 1'b0;
        reg_dat_we = 1'b1; reg_dat_di = 32'hAB;
        for (int i = 0; i < 3; i++) cycle();
        #4;
        resetn = 1'b0;
        #1;
        check("t6_wait", reg_dat_wait, 1'b0);
        check("t6_valid", uart_in_valid, 1'b0);
        check("t6_stat", reg_stat_do, 32'h0);
        @(posedge clk); #1;
        idle();
        model_clear();
        resetn = 1'b1;
        reg_dat_re = 1'b1;
        check("t6_first_read", reg_dat_do, 32'hFFFF_FFFF);
        cycle();
        idle();

        // 7: random traffic
        for (int blk = 0; blk < 12; blk++) begin
            int rdy_bias;
            rdy_bias = $urandom_range(0, 3);
            for (int i = 0; i < 200; i++) begin
                if (!last_wait || $urandom_range(0, 15) == 0) begin
                    reg_dat_we = ($urandom_range(0, 1) == 1);
                    reg_dat_di = $urandom;
                end
                reg_dat_re     = ($urandom_range(0, 2) == 0);
                uart_in_ready  = ($urandom_range(0, 3) < rdy_bias);
                uart_out_valid = ($urandom_range(0, 1) == 1);
                uart_out_data  = 8'($urandom);
                if ($urandom_range(0, 19) == 0) begin
                    reg_stat_we = 4'($urandom);
                    reg_stat_di = $urandom & 32'hC004_0000;
                end else begin
                    reg_stat_we = 4'h0;
                    reg_stat_di = 32'h0;
                end
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
